// File: rtl/big_alu_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, registered
// quotient/remainder with a one-cycle completion pulse and divide-by-zero flag.
module big_alu_divider #(
    parameter int unsigned W = 23
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] valor1,
    input  logic [W-1:0] valor2,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         busy,
    output logic         endDivision,
    output logic         divByZero
);

    localparam int unsigned CW = $clog2(W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t        r_state;
    logic [W-1:0]  r_dq;
    logic [W-1:0]  r_dv;
    logic [W-1:0]  r_acc;
    logic [CW-1:0] r_cnt;

    logic [W:0]    w_t;
    logic [W:0]    w_diff;
    logic          w_ge;
    logic [W-1:0]  w_acc_next;
    logic [W-1:0]  w_dq_next;

    // The running remainder always stays below the divisor, so the top bit of
    // the W+1-bit difference is exactly the borrow of t - dv.
    always_comb begin
        w_t        = {r_acc, r_dq[W-1]};
        w_diff     = w_t - {1'b0, r_dv};
        w_ge       = ~w_diff[W];
        w_acc_next = w_ge ? w_diff[W-1:0] : w_t[W-1:0];
        w_dq_next  = {r_dq[W-2:0], w_ge};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_dq        <= '0;
            r_dv        <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            busy        <= 1'b0;
            endDivision <= 1'b0;
            divByZero   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (valor2 != '0) begin
                            r_dq    <= valor1;
                            r_dv    <= valor2;
                            r_acc   <= '0;
                            r_cnt   <= CW'(W - 1);
                            r_state <= S_RUN;
                        end else begin
                            quotient    <= '1;
                            remainder   <= valor1;
                            divByZero   <= 1'b1;
                            endDivision <= 1'b1;
                            r_state     <= S_DONE;
                        end
                    end
                end
                S_RUN: begin
                    r_acc <= w_acc_next;
                    r_dq  <= w_dq_next;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        quotient    <= w_dq_next;
                        remainder   <= w_acc_next;
                        divByZero   <= 1'b0;
                        endDivision <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    endDivision <= 1'b0;
                    busy        <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_big_alu_divider.sv
// Scoreboard bench for big_alu_divider: expected results queued at issue time,
// compared when the completion pulse appears.
module tb_big_alu_divider;

    localparam int unsigned W = 23;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] valor1;
    logic [W-1:0] valor2;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         endDivision;
    logic         divByZero;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } exp_t;

    exp_t         sb[$];
    int           n_checks = 0;
    int           n_errors = 0;
    logic [W-1:0] prev_q  = '0;
    logic [W-1:0] prev_r  = '0;
    logic         prev_dz = 1'b0;

    big_alu_divider #(.W(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .valor1      (valor1),
        .valor2      (valor2),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .endDivision (endDivision),
        .divByZero   (divByZero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        if (b == '0) begin
            e.q  = '1;
            e.r  = a;
            e.dz = 1'b1;
        end else begin
            e.q  = a / b;
            e.r  = a % b;
            e.dz = 1'b0;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (!reset && endDivision) begin
            if (sb.size() == 0) begin
                check("spurious_end", 32'(endDivision), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("quotient", 32'(quotient), 32'(e.q));
                check("remainder", 32'(remainder), 32'(e.r));
                check("divByZero", 32'(divByZero), 32'(e.dz));
                prev_q  = e.q;
                prev_r  = e.r;
                prev_dz = e.dz;
            end
        end
    end

    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit poke);
        int n;
        bit held;
        @(negedge clk);
        start  = 1'b1;
        valor1 = a;
        valor2 = b;
        sb.push_back(model(a, b));
        @(posedge clk);
        #1;
        start  = 1'b0;
        valor1 = W'($urandom);
        valor2 = W'($urandom);
        check("busy_accept", 32'(busy), 32'd1);
        held = 1'b1;
        n = 0;
        while (!endDivision && n < 100) begin
            if (quotient !== prev_q || remainder !== prev_r || divByZero !== prev_dz)
                held = 1'b0;
            if (poke && n == 3) begin
                start  = 1'b1;
                valor1 = W'(30);
                valor2 = W'(4);
            end
            if (poke && n == 8) start = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        start = 1'b0;
        check("latency", 32'(n), (b == '0) ? 32'd0 : 32'(W));
        check("hold_prev", 32'(held), 32'd1);
        @(posedge clk);
        #1;
        check("end_one_cycle", 32'(endDivision), 32'd0);
        check("busy_release", 32'(busy), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_q"}, 32'(quotient), 32'd0);
        check({tag, "_r"}, 32'(remainder), 32'd0);
        check({tag, "_dz"}, 32'(divByZero), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_end"}, 32'(endDivision), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ends;
        reset  = 1'b1;
        start  = 1'b0;
        valor1 = '0;
        valor2 = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        run_div(W'(100), W'(7), 1'b0);
        run_div(W'(20), W'(5), 1'b0);
        run_div(W'(5), W'(20), 1'b0);
        run_div(W'('h7FFFFF), W'(1), 1'b0);
        run_div(W'('h7FFFFF), W'('h7FFFFF), 1'b0);
        run_div(W'(0), W'(9), 1'b0);
        run_div(W'(20), W'(0), 1'b0);
        run_div(W'(20), W'(5), 1'b0);
        run_div(W'(100), W'(7), 1'b1);

        // abort a division at iteration 10; no result must be queued or seen
        @(negedge clk);
        start  = 1'b1;
        valor1 = W'(1000);
        valor2 = W'(3);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("abort");
        prev_q  = '0;
        prev_r  = '0;
        prev_dz = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        ends = 0;
        repeat (30) begin
            @(negedge clk);
            if (endDivision) ends++;
        end
        check("abort_no_end", 32'(ends), 32'd0);
        check_all_zero("after_abort");

        run_div(W'(30), W'(4), 1'b0);

        for (int i = 0; i < 6; i++)
            run_div(W'($urandom), W'($urandom_range(1, 5000)), 1'b0);

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
